// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared state encodings and counter sizing for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic int cnt_w(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_sub_ctrl_if.sv
// rtl/serial_sub_ctrl_if.sv - requester-side handshake and operand/result bus (Ovf with SERIAL_SUB_OVF_EN)
interface serial_sub_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Borrow;
`ifdef SERIAL_SUB_OVF_EN
    logic             Ovf;

    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow, Ovf
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow, Ovf
    );
`else
    modport master (
        output start, A, B,
        input  busy, done, Diff, Borrow
    );

    modport slave (
        input  start, A, B,
        output busy, done, Diff, Borrow
    );
`endif

endinterface

// File: rtl/serial_sub_ctrl_fs_bit_cell.sv
// rtl/serial_sub_ctrl_fs_bit_cell.sv - combinational 1-bit full subtractor from two half-subtract stages
module fs_bit_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    logic w_d1;
    logic w_b1;
    logic w_b2;

    assign w_d1   = i_a ^ i_b;
    assign w_b1   = ~i_a & i_b;
    assign o_d    = w_d1 ^ i_bin;
    assign w_b2   = ~w_d1 & i_bin;
    assign o_bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// rtl/serial_sub_ctrl.sv - bit-serial A-B controller, LSB first over WIDTH cycles (Ovf with SERIAL_SUB_OVF_EN)
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    serial_sub_ctrl_if.slave  bus
);

    localparam int              CNT_W    = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_diff;
    logic [CNT_W-1:0] r_cnt;
    logic             r_bflop;
    logic             r_borrow;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_SUB_OVF_EN
    logic             r_sa;
    logic             r_sb;
    logic             r_ovf;
`endif

    fs_bit_cell u_cell (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_bin  (r_bflop),
        .o_d    (w_d),
        .o_bout (w_bout)
    );

    assign w_last     = (r_cnt == LAST_CNT);
    assign w_res_next = {w_d, r_res[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.start) w_next = ST_SHIFT;
            ST_SHIFT: if (w_last)    w_next = ST_DONE;
            ST_DONE:                 w_next = ST_IDLE;
            default:                 w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (r_state == ST_SHIFT);
        bus.done = (r_state == ST_DONE);
    end

    // Result registers only move on the final shift, so Diff stays stable throughout SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_bflop  <= 1'b0;
            r_borrow <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.A;
                        r_b     <= bus.B;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_bflop <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
                        r_sa    <= bus.A[WIDTH-1];
                        r_sb    <= bus.B[WIDTH-1];
`endif
                    end
                end
                ST_SHIFT: begin
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_bflop <= w_bout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff   <= w_res_next;
                        r_borrow <= w_bout;
`ifdef SERIAL_SUB_OVF_EN
                        r_ovf    <= (r_sa != r_sb) & (w_d != r_sa);
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.Diff   = r_diff;
    assign bus.Borrow = r_borrow;
`ifdef SERIAL_SUB_OVF_EN
    assign bus.Ovf    = r_ovf;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb/tb_serial_sub_ctrl.sv - directed self-checking bench for serial_sub_ctrl, WIDTH=8
module tb_serial_sub_ctrl;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    serial_sub_ctrl_if #(.WIDTH(8)) ifc ();

    serial_sub_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launches one op; afterwards A/B are scrambled to show they are ignored during SHIFT.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output int n_busy, output int lat, output int n_done);
        n_busy = 0;
        lat    = -1;
        n_done = 0;
        @(negedge clk);
        ifc.A     = a;
        ifc.B     = b;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        ifc.A     = ~a;
        ifc.B     = a;
        for (int j = 0; j < 14; j++) begin
            if (ifc.busy) n_busy++;
            if (ifc.done) begin
                n_done++;
                if (lat < 0) lat = j;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        ifc.start = 1'b0;
        ifc.A     = '0;
        ifc.B     = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({ifc.busy, ifc.done, ifc.Borrow} !== 3'b000) begin
            bad++;
            $display("FAIL reset_flags busy/done/borrow=%b want 000", {ifc.busy, ifc.done, ifc.Borrow});
        end
        total++;
        if (ifc.Diff !== 8'h00) begin
            bad++;
            $display("FAIL reset_diff got=%h want=00", ifc.Diff);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ifc.Ovf !== 1'b0) begin
            bad++;
            $display("FAIL reset_ovf got=%b want=0", ifc.Ovf);
        end
`endif
        ifc.start = 1'b1;
        ifc.A     = 8'h05;
        ifc.B     = 8'h03;
        @(negedge clk);
        ifc.start = 1'b0;
        rst       = 1'b0;
        @(negedge clk);
        total++;
        if (ifc.busy !== 1'b0) begin
            bad++;
            $display("FAIL rst_beats_start busy=%b want=0", ifc.busy);
        end
    endtask

    task automatic test_basic(input string name, input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp_d, input logic exp_bo, input logic exp_ov);
        int n_busy, lat, n_done;
        run_op(a, b, n_busy, lat, n_done);
        total++;
        if (n_busy != 8 || lat != 8 || n_done != 1) begin
            bad++;
            $display("FAIL %s_timing busy=%0d lat=%0d dones=%0d want 8/8/1", name, n_busy, lat, n_done);
        end
        total++;
        if (ifc.Diff !== exp_d || ifc.Borrow !== exp_bo) begin
            bad++;
            $display("FAIL %s_result diff=%h borrow=%b want %h/%b", name, ifc.Diff, ifc.Borrow, exp_d, exp_bo);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ifc.Ovf !== exp_ov) begin
            bad++;
            $display("FAIL %s_ovf got=%b want=%b", name, ifc.Ovf, exp_ov);
        end
`else
        if (exp_ov === 1'bx) $display("note: no ovf expectation for %s", name);
`endif
    endtask

    task automatic test_start_ignored();
        int n_done;
        int n_busy;
        n_done = 0;
        n_busy = 0;
        @(negedge clk);
        ifc.A     = 8'hFF;
        ifc.B     = 8'h01;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        for (int j = 0; j < 16; j++) begin
            if (ifc.busy) n_busy++;
            if (ifc.done) n_done++;
            if (j == 2) begin
                ifc.A     = 8'h00;
                ifc.B     = 8'h01;
                ifc.start = 1'b1;
            end else begin
                ifc.start = 1'b0;
            end
            if (j == 5) begin
                total++;
                if (ifc.Diff !== 8'h02) begin
                    bad++;
                    $display("FAIL diff_stable_in_shift got=%h want=02", ifc.Diff);
                end
            end
            @(negedge clk);
        end
        total++;
        if (n_done != 1 || n_busy != 8) begin
            bad++;
            $display("FAIL ignore_start dones=%0d busy=%0d want 1/8", n_done, n_busy);
        end
        total++;
        if (ifc.Diff !== 8'hFE || ifc.Borrow !== 1'b0) begin
            bad++;
            $display("FAIL ignore_start_result diff=%h borrow=%b want fe/0", ifc.Diff, ifc.Borrow);
        end
    endtask

    task automatic test_reset_mid_op();
        int n_done;
        n_done = 0;
        @(negedge clk);
        ifc.A     = 8'h80;
        ifc.B     = 8'h01;
        ifc.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({ifc.busy, ifc.done, ifc.Borrow} !== 3'b000 || ifc.Diff !== 8'h00) begin
            bad++;
            $display("FAIL mid_reset busy/done/borrow=%b diff=%h want 000/00",
                     {ifc.busy, ifc.done, ifc.Borrow}, ifc.Diff);
        end
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            if (ifc.done) n_done++;
        end
        total++;
        if (n_done != 0) begin
            bad++;
            $display("FAIL mid_reset_no_done dones=%0d want=0", n_done);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea [3] = '{8'h10, 8'h7F, 8'hAA};
        logic [7:0] eb [3] = '{8'h20, 8'hFF, 8'h55};
        logic [7:0] ed [3] = '{8'hF0, 8'h80, 8'h55};
        logic       ebo[3] = '{1'b1, 1'b1, 1'b0};
        logic       eov[3] = '{1'b0, 1'b1, 1'b1};
        int idx;
        int last;
        idx  = 0;
        last = -1;
        @(negedge clk);
        ifc.A     = ea[0];
        ifc.B     = eb[0];
        ifc.start = 1'b1;
        for (int c = 0; c < 60 && idx < 3; c++) begin
            @(negedge clk);
            if (ifc.done) begin
                total++;
                if (ifc.Diff !== ed[idx] || ifc.Borrow !== ebo[idx]) begin
                    bad++;
                    $display("FAIL b2b_result%0d diff=%h borrow=%b want %h/%b",
                             idx, ifc.Diff, ifc.Borrow, ed[idx], ebo[idx]);
                end
`ifdef SERIAL_SUB_OVF_EN
                total++;
                if (ifc.Ovf !== eov[idx]) begin
                    bad++;
                    $display("FAIL b2b_ovf%0d got=%b want=%b", idx, ifc.Ovf, eov[idx]);
                end
`else
                if (eov[idx] === 1'bx) $display("note: no ovf expectation");
`endif
                if (last >= 0) begin
                    total++;
                    if (c - last != 10) begin
                        bad++;
                        $display("FAIL b2b_spacing%0d got=%0d want=10", idx, c - last);
                    end
                end
                last = c;
                idx++;
                if (idx < 3) begin
                    ifc.A = ea[idx];
                    ifc.B = eb[idx];
                end else begin
                    ifc.start = 1'b0;
                end
            end
        end
        total++;
        if (idx != 3) begin
            bad++;
            $display("FAIL b2b_timeout dones=%0d want=3", idx);
        end
        ifc.start = 1'b0;
        repeat (14) @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_basic("sub_05_03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        test_basic("sub_03_05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
        test_basic("sub_80_01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        test_basic("sub_00_00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        test_basic("sub_05_03b", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
